hubris_fetch_unit: RTL

Parametrised instruction-fetch front end for the Hubris pipeline. It owns the program counter, issues pipelined requests to the instruction port of the unified memory and buffers returned instructions with their PCs in a prefetch queue. It presents them to the IF/ID register through a valid/ready handshake, and flushes cleanly on a branch or jump redirect from EX. This lets ID stall without a PC freeze, and lets memory latency exceed one cycle.

---
 rtl/hubris_pkg.sv | 20 ++
 rtl/hubris_sync_fifo.sv | 65 ++++++
 rtl/hubris_fetch_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hubris_pkg.sv
// -----------------------------------------------------------------------------
// hubris_pkg
// Shared definitions for the Hubris instruction-fetch front end:
//   ADDR_WIDTH_DEF / INST_WIDTH_DEF : default address / instruction widths
//   NOP_INST                        : canonical no-op (addi x0, x0, 0)
//   fetch_entry_t                   : {pc, inst} pair at the default widths
// -----------------------------------------------------------------------------
package hubris_pkg;

   localparam int ADDR_WIDTH_DEF = 32;
   localparam int INST_WIDTH_DEF = 32;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] pc;
      logic [INST_WIDTH_DEF-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/hubris_sync_fifo.sv
// -----------------------------------------------------------------------------
// hubris_sync_fifo
// Single-clock FIFO with synchronous flush. Pointers carry one extra wrap bit
// so that full and empty are distinguished without a separate counter.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : empties the FIFO at the next edge (wins over push/pop)
//   push         : write push_data (accepted when not full, or when popping)
//   push_data    : WIDTH-bit write data
//   pop          : remove the head entry (ignored when empty)
//   head_data    : entry at the head (stale content when empty)
//   count        : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module hubris_sync_fifo
   import hubris_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;
   logic             empty;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty = (wr_ptr == rd_ptr);
   // Same slot, opposite lap: the writer has gone all the way round.
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign count = wr_ptr - rd_ptr;

   assign do_pop  = pop && !empty;
   // When full, the slot being written is the one being popped this cycle.
   assign do_push = push && (!full || do_pop);

   assign head_data = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr[PW-1:0]] <= push_data;
   end

endmodule

// File: rtl/hubris_fetch_unit.sv
// -----------------------------------------------------------------------------
// hubris_fetch_unit
// Instruction-fetch front end: owns the PC, issues pipelined requests to the
// instruction memory port, buffers returned words with their PCs in a prefetch
// queue and hands them to ID through a valid/ready handshake. A redirect from
// EX flushes the queue and discards every response still in flight.
//
// Optional feature macro: HUBRIS_FETCH_BYPASS_EN
//   defined   : a response arriving while the queue is empty (and nothing is
//               being dropped) is presented to ID in the same cycle, and is
//               not queued if ID takes it immediately.
//   undefined : every response passes through the queue (1-cycle latency).
//
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   redirect_valid, redirect_addr   : EX change of flow (highest priority)
//   imem_req_valid/ready/addr       : request channel to instruction memory
//   imem_resp_valid/data            : in-order response channel
//   out_valid/ready, out_inst/pc    : instruction handshake towards ID
//   occupancy                       : number of queued entries
// -----------------------------------------------------------------------------
module hubris_fetch_unit
   import hubris_pkg::*;
#(
   parameter int                    ADDR_WIDTH      = ADDR_WIDTH_DEF,
   parameter int                    INST_WIDTH      = INST_WIDTH_DEF,
   parameter int                    QUEUE_DEPTH     = 4,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter logic [ADDR_WIDTH-1:0] INST_START_ADDR = '0
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           redirect_valid,
   input  logic [ADDR_WIDTH-1:0]          redirect_addr,
   output logic                           imem_req_valid,
   input  logic                           imem_req_ready,
   output logic [ADDR_WIDTH-1:0]          imem_req_addr,
   input  logic                           imem_resp_valid,
   input  logic [INST_WIDTH-1:0]          imem_resp_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [INST_WIDTH-1:0]          out_inst,
   output logic [ADDR_WIDTH-1:0]          out_pc,
   output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

   localparam int                    OUT_W     = $clog2(MAX_OUTSTANDING + 1);
   localparam int                    ENT_W     = ADDR_WIDTH + INST_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PC_STEP   = ADDR_WIDTH'(4);
   localparam logic [31:0]           MAX_OUT_U = MAX_OUTSTANDING;
   localparam logic [31:0]           DEPTH_U   = QUEUE_DEPTH;

   logic [ADDR_WIDTH-1:0] fetch_pc;
   logic [ADDR_WIDTH-1:0] resp_pc;
   logic [OUT_W-1:0]      outstanding;
   logic [OUT_W-1:0]      drop;
   logic [ENT_W-1:0]      head_entry;
   logic [ENT_W-1:0]      hold_entry;
   logic [31:0]           committed;
   logic                  fifo_empty;
   logic                  drop_active;
   logic                  resp_keep;
   logic                  bypass;
   logic                  req_fire;
   logic                  push;
   logic                  pop;

   hubris_sync_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (QUEUE_DEPTH)
   ) u_queue (
      .clk       (clk),
      .reset     (reset),
      .flush     (redirect_valid),
      .push      (push),
      .push_data ({resp_pc, imem_resp_data}),
      .pop       (pop),
      .head_data (head_entry),
      .count     (occupancy)
   );

   assign fifo_empty  = (occupancy == '0);
   assign drop_active = (drop != '0);
   assign resp_keep   = imem_resp_valid && !drop_active && !redirect_valid;

`ifdef HUBRIS_FETCH_BYPASS_EN
   assign bypass = resp_keep && fifo_empty;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = !fifo_empty || bypass;
   assign pop       = !fifo_empty && out_ready;
   // A bypassed word that ID takes immediately never occupies a slot.
   assign push      = resp_keep && !(bypass && out_ready);

   always_comb begin
      if (!fifo_empty)  {out_pc, out_inst} = head_entry;
      else if (bypass)  {out_pc, out_inst} = {resp_pc, imem_resp_data};
      else              {out_pc, out_inst} = hold_entry;
   end

   // Requests whose responses will be kept reserve a queue slot up front, so
   // a response can always be accepted; responses being dropped reserve none.
   assign committed      = 32'(occupancy) + 32'(outstanding) - 32'(drop);
   assign imem_req_valid = !reset && !redirect_valid
                           && (32'(outstanding) < MAX_OUT_U)
                           && (committed < DEPTH_U);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= INST_START_ADDR;
         resp_pc     <= INST_START_ADDR;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         if (req_fire && !imem_resp_valid)
            outstanding <= outstanding + OUT_W'(1);
         else if (!req_fire && imem_resp_valid)
            outstanding <= outstanding - OUT_W'(1);

         if (redirect_valid) begin
            fetch_pc <= redirect_addr;
            resp_pc  <= redirect_addr;
            // Responses already marked for dropping are part of outstanding,
            // so everything still in flight after this cycle is dropped.
            drop     <= outstanding - OUT_W'(imem_resp_valid);
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + PC_STEP;
            if (resp_keep) resp_pc  <= resp_pc + PC_STEP;
            if (imem_resp_valid && drop_active) drop <= drop - OUT_W'(1);
         end
      end
   end

   // Keeps out_pc/out_inst stable (and defined) while out_valid is low.
   always_ff @(posedge clk) begin
      if (reset) hold_entry <= {INST_START_ADDR, INST_WIDTH'(NOP_INST)};
      else       hold_entry <= {out_pc, out_inst};
   end

endmodule
